// File: rtl/jedro_1_dmem_pkg.sv
// Shared types and constants for the jedro_1 data-memory responder.
package jedro_1_dmem_pkg;

   localparam int unsigned LANES = 4;

   typedef logic [LANES-1:0] be_t;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_t;

endpackage

// File: rtl/jedro_1_dmem_array.sv
// DEPTH x 32-bit word RAM with per-byte write enables and a registered read port.
module jedro_1_dmem_array
   import jedro_1_dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] idx_i,
   input  be_t              be_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int n = 0; n < int'(LANES); n++) begin
            if (be_i[n]) mem[idx_i][8*n +: 8] <= wdata_i[8*n +: 8];
         end
      end
      if (re_i) rdata_o <= mem[idx_i];
   end

endmodule

// File: rtl/jedro_1_dmem_responder.sv
// Data-memory responder: one outstanding load/store, response after LATENCY cycles.
// Optional access-fault checking is enabled with the JEDRO_1_DMEM_ERR_EN macro.
module jedro_1_dmem_responder
   import jedro_1_dmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   output logic                  ready_o,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  be_t                   be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  zero_q;
   logic                  fault_q;
   logic [DATA_WIDTH-1:0] hold_q;
   logic [DATA_WIDTH-1:0] arr_rdata;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  accept;
   logic                  fault;

   // A request seen during reset must not commit a store.
   assign accept = req_i & ready_o & ~rst_i;

`ifdef JEDRO_1_DMEM_ERR_EN
   assign fault = (addr_i[1:0] != 2'b00) || (addr_i >= ADDR_WIDTH'(DEPTH * LANES));
`else
   logic unused_addr;
   assign fault       = 1'b0;
   assign unused_addr = ^{addr_i[1:0], addr_i[ADDR_WIDTH-1:IDX_W+2]};
`endif

   jedro_1_dmem_array #(
      .DEPTH(DEPTH)
   ) u_array (
      .clk_i  (clk_i),
      .we_i   (accept & we_i & ~fault),
      .re_i   (accept & ~we_i & ~fault),
      .idx_i  (addr_i[IDX_W+1:2]),
      .be_i   (be_i),
      .wdata_i(wdata_i),
      .rdata_o(arr_rdata)
   );

   // Stores and faulting loads answer with zero; otherwise the word captured at accept.
   assign resp_data = zero_q ? '0 : arr_rdata;
   assign rdata_o   = rvalid_o ? resp_data : hold_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         ready_o  <= 1'b0;
         rvalid_o <= 1'b0;
         err_o    <= 1'b0;
         zero_q   <= 1'b1;
         fault_q  <= 1'b0;
         hold_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  ready_o <= 1'b0;
                  zero_q  <= we_i | fault;
                  fault_q <= fault;
                  cnt_q   <= 4'(LATENCY - 1);
                  if (LATENCY == 1) begin
                     state_q  <= StResp;
                     rvalid_o <= 1'b1;
                     err_o    <= fault;
                  end else begin
                     state_q <= StWait;
                  end
               end else begin
                  ready_o <= 1'b1;
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q  <= StResp;
                  rvalid_o <= 1'b1;
                  err_o    <= fault_q;
               end
            end
            StResp: begin
               rvalid_o <= 1'b0;
               err_o    <= 1'b0;
               ready_o  <= 1'b1;
               hold_q   <= resp_data;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_jedro_1_dmem_responder.sv
// Randomized bench for jedro_1_dmem_responder: two instances (LATENCY 1 and 3) vs. a word-array model.
module tb_jedro_1_dmem_responder;

   localparam int unsigned DEPTH = 64;
`ifdef JEDRO_1_DMEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst    [2];
   logic        req    [2];
   logic        ready  [2];
   logic        we     [2];
   logic [31:0] addr   [2];
   logic [3:0]  be     [2];
   logic [31:0] wdata  [2];
   logic        rvalid [2];
   logic [31:0] rdata  [2];
   logic        err    [2];

   logic [31:0] mem_m [2][DEPTH];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jedro_1_dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
      .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .ready_o(ready[0]), .we_i(we[0]),
      .addr_i(addr[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .err_o(err[0])
   );

   jedro_1_dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) dut_l3 (
      .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .ready_o(ready[1]), .we_i(we[1]),
      .addr_i(addr[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .err_o(err[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Reference behaviour: returns the expected response and commits stores to the model.
   task automatic model_access(input int d, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] wd,
                               output logic [31:0] exp_rd, output logic exp_err);
      int unsigned idx;
      logic [31:0] word;
      exp_err = ERR_EN && ((a % 4) != 0 || a >= DEPTH * 4);
      idx     = (a % (DEPTH * 4)) / 4;
      exp_rd  = 32'h0;
      if (!exp_err) begin
         if (w) begin
            word = mem_m[d][idx];
            for (int n = 0; n < 4; n++)
               if (b[n]) word[8*n +: 8] = wd[8*n +: 8];
            mem_m[d][idx] = word;
         end else begin
            exp_rd = mem_m[d][idx];
         end
      end
   endtask

   // Called right after a negedge; returns right after a negedge.
   task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, input bit hold, output logic [31:0] rd_out,
                      output logic err_out);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          k;
      bit          got;
      rd_out  = 32'h0;
      err_out = 1'b0;
      req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
      k = 0;
      while (ready[d] !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (ready[d] !== 1'b1) begin
         check("ready_timeout", {31'h0, ready[d]}, 32'h1);
         req[d] = 1'b0;
         return;
      end
      model_access(d, w, a, b, wd, exp_rd, exp_err);
      @(negedge clk);
      k   = 1;
      got = 1'b0;
      while (k <= 20) begin
         if (hold) begin
            we[d] = 1'($urandom); addr[d] = $urandom_range(0, DEPTH * 4 - 1);
            be[d] = 4'hF; wdata[d] = $urandom;
         end else begin
            req[d] = 1'b0;
         end
         if (rvalid[d] === 1'b1) begin
            got = 1'b1;
            break;
         end
         check("ready_busy", {31'h0, ready[d]}, 32'h0);
         @(negedge clk);
         k++;
      end
      req[d] = 1'b0;
      if (!got) begin
         check("rvalid_timeout", 32'h0, 32'h1);
         return;
      end
      check("latency", k, lat_of(d));
      check("rdata", rdata[d], exp_rd);
      check("err", {31'h0, err[d]}, {31'h0, exp_err});
      check("ready_resp", {31'h0, ready[d]}, 32'h0);
      rd_out  = rdata[d];
      err_out = err[d];
      @(negedge clk);
      check("rvalid_pulse", {31'h0, rvalid[d]}, 32'h0);
      check("ready_back", {31'h0, ready[d]}, 32'h1);
      check("rdata_hold", rdata[d], exp_rd);
      check("err_clear", {31'h0, err[d]}, 32'h0);
   endtask

   task automatic check_reset_outputs(input int d);
      check("rst_ready", {31'h0, ready[d]}, 32'h0);
      check("rst_rvalid", {31'h0, rvalid[d]}, 32'h0);
      check("rst_rdata", rdata[d], 32'h0);
      check("rst_err", {31'h0, err[d]}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd, rd2, word0;
      logic        er;
      logic [31:0] a;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) check_reset_outputs(d);
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);

      // Fill both arrays so every model word is known.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < int'(DEPTH); i++)
            txn(d, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, rd, er);

      // Store 13 to 0x0/0x4, load back.
      txn(0, 1'b1, 32'h0, 4'hF, 32'd13, 1'b0, rd, er);
      txn(0, 1'b1, 32'h4, 4'hF, 32'd13, 1'b0, rd, er);
      txn(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, rd, er);
      check("t1_load0", rd, 32'h0000000D);
      txn(0, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0, rd, er);
      check("t1_load4", rd, 32'h0000000D);

      // Partial byte-lane store.
      txn(0, 1'b1, 32'h8, 4'hF, 32'h11223344, 1'b0, rd, er);
      txn(0, 1'b1, 32'h8, 4'b0001, 32'h000000AB, 1'b0, rd, er);
      txn(0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0, rd, er);
      check("t2_lane", rd, 32'h112233AB);
      txn(0, 1'b1, 32'h8, 4'b0000, 32'hFFFFFFFF, 1'b0, rd, er);
      check("t2_store_rdata", rd, 32'h0);
      txn(0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0, rd, er);
      check("t2_be0", rd, 32'h112233AB);

      // LATENCY=3 timing, and request held/changing while busy.
      txn(1, 1'b1, 32'h20, 4'hF, 32'h5A5A1234, 1'b0, rd, er);
      txn(1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, rd, er);
      check("t4_held", rd, 32'h5A5A1234);

      // Misaligned and out-of-range accesses.
      txn(0, 1'b1, 32'h0, 4'hF, 32'h600DF00D, 1'b0, rd, er);
      word0 = 32'h600DF00D;
      txn(0, 1'b0, 32'h2, 4'h0, 32'h0, 1'b0, rd, er);
      check("t5_misalign_rd", rd, ERR_EN ? 32'h0 : word0);
      check("t5_misalign_err", {31'h0, er}, {31'h0, ERR_EN});
      txn(0, 1'b1, 32'(DEPTH * 4), 4'hF, 32'hDEADBEEF, 1'b0, rd, er);
      check("t5_oor_err", {31'h0, er}, {31'h0, ERR_EN});
      txn(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, rd2, er);
      check("t5_oor_array", rd2, ERR_EN ? word0 : 32'hDEADBEEF);

      // Reset while the LATENCY=3 instance is waiting on a store.
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h10; be[1] = 4'hF; wdata[1] = 32'hCAFEF00D;
      begin
         int k = 0;
         while (ready[1] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
         end
         check("t6_ready", {31'h0, ready[1]}, 32'h1);
      end
      model_access(1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, rd, er);
      @(negedge clk);
      req[1] = 1'b0;
      rst[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t6_no_rvalid", {31'h0, rvalid[1]}, 32'h0);
         @(negedge clk);
      end
      check_reset_outputs(1);
      rst[1] = 1'b0;
      @(negedge clk);
      txn(1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, er);
      check("t6_kept", rd, 32'hCAFEF00D);

      // Random traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         int d = i % 2;
         if ($urandom_range(0, 7) == 0) a = $urandom;
         else a = $urandom_range(0, DEPTH * 8 - 1);
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         txn(d, 1'($urandom), a, 4'($urandom), $urandom, 1'($urandom_range(0, 3) == 0), rd, er);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
